// File: rtl/bq_pkg.sv
// Shared definitions for the biquad coefficient loader.
//   - Register index constants for the five coefficients (a11, a12, b10, b11, b12).
//   - Loader state encoding.
//   - Byte stride between consecutive coefficient registers and an offset helper.
package bq_pkg;

  localparam int unsigned NUM_COEF = 5;

  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_B10 = 3'd2;
  localparam logic [2:0] IDX_B11 = 3'd3;
  localparam logic [2:0] IDX_B12 = 3'd4;

  localparam logic [31:0] ADDR_STRIDE = 32'd4;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StGap,
    StRd,
    StFin
  } state_e;

  // Byte offset of coefficient register idx from the slave's base address.
  function automatic logic [31:0] coef_offset(input logic [2:0] idx);
    return 32'(idx) * ADDR_STRIDE;
  endfunction

endpackage

// File: rtl/bq_coef_loader.sv
// Wishbone classic master that writes the five biquad coefficients into the filter's
// coefficient register file and optionally reads them back to verify.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   start                       one-cycle load request (ignored unless idle)
//   a11, a12, b10, b11, b12     coefficient values, captured on an accepted start
//   wb_cyc_o .. wb_dat_o        Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i          Wishbone slave read data and acknowledge
//   busy                        high while a load is in progress
//   done                        one-cycle completion pulse (success or abort)
//   err_timeout, err_mismatch   sticky error flags, cleared by the next accepted start
//   err_idx                     index of the first failing register
module bq_coef_loader
  import bq_pkg::*;
#(
  parameter int unsigned COEFWIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned VERIFY    = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic [COEFWIDTH-1:0] a11,
  input  logic [COEFWIDTH-1:0] a12,
  input  logic [COEFWIDTH-1:0] b10,
  input  logic [COEFWIDTH-1:0] b11,
  input  logic [COEFWIDTH-1:0] b12,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_mismatch,
  output logic [2:0]           err_idx
);

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  state_e               state_q, state_d;
  state_e               pend_q, pend_d;    // phase entered when the current GAP ends
  logic [2:0]           idx_q, idx_d;
  logic [COEFWIDTH-1:0] shadow_q [NUM_COEF];
  logic [COEFWIDTH-1:0] shadow_d [NUM_COEF];
  logic [7:0]           wait_q, wait_d;
  logic [8:0]           wait_inc;
  logic                 last_idx;

  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_to_q, err_to_d;
  logic        err_mm_q, err_mm_d;
  logic [2:0]  err_idx_q, err_idx_d;

  // Only the low COEFWIDTH bits of read data are meaningful.
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;

  assign wait_inc = {1'b0, wait_q} + 9'd1;
  assign last_idx = (idx_q == IDX_B12);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    wait_d    = wait_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_to_d  = err_to_q;
    err_mm_d  = err_mm_q;
    err_idx_d = err_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d[IDX_A11] = a11;
          shadow_d[IDX_A12] = a12;
          shadow_d[IDX_B10] = b10;
          shadow_d[IDX_B11] = b11;
          shadow_d[IDX_B12] = b12;
          err_to_d  = 1'b0;
          err_mm_d  = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          // A leading GAP cycle registers the first bus request one cycle after start.
          pend_d    = StWr;
          state_d   = StGap;
        end
      end

      StGap: begin
        state_d = pend_q;
        wait_d  = '0;
        if (pend_q == StWr || pend_q == StRd) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = (pend_q == StWr);
          adr_d = BASE_ADDR + coef_offset(idx_q);
          if (pend_q == StWr) begin
            dat_d = 32'($signed(shadow_q[idx_q]));
          end
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      StWr, StRd: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = StGap;
          idx_d   = last_idx ? 3'd0 : idx_q + 3'd1;
          if (state_q == StWr) begin
            pend_d = !last_idx ? StWr : ((VERIFY != 0) ? StRd : StFin);
          end else begin
            pend_d = last_idx ? StFin : StRd;
            if (wb_dat_i[COEFWIDTH-1:0] != shadow_q[idx_q] && !err_mm_q) begin
              err_mm_d  = 1'b1;
              err_idx_d = idx_q;
            end
          end
        end else if (wait_inc == TimeoutLim) begin
          // Abort: no further transfers, go straight to the done cycle.
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          err_to_d = 1'b1;
          if (!err_mm_q) begin
            err_idx_d = idx_q;
          end
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StFin;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      pend_q    <= StWr;
      idx_q     <= '0;
      wait_q    <= '0;
      for (int i = 0; i < int'(NUM_COEF); i++) begin
        shadow_q[i] <= '0;
      end
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= BASE_ADDR;
      dat_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_mm_q  <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      shadow_q  <= shadow_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_to_q  <= err_to_d;
      err_mm_q  <= err_mm_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = 4'hF;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_to_q;
  assign err_mismatch = err_mm_q;
  assign err_idx      = err_idx_q;

endmodule

// File: tb/tb_bq_coef_loader.sv
// Bench for bq_coef_loader: scoreboard of expected bus transfers and completion results,
// checked by an independent monitor against a Wishbone slave model with per-transfer latency.
module tb_bq_coef_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          dur;
  } xfer_t;

  typedef struct {
    int         at;
    logic       to;
    logic       mm;
    logic [2:0] idx;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start_b;
  logic [15:0] a11, a12, b10, b11, b12;

  logic        cyc, stb, we, ack, busy, done, e_to, e_mm;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic [2:0]  e_idx;

  logic        cyc_b, stb_b, we_b, ack_b, busy_b, done_b, e_to_b, e_mm_b;
  logic [3:0]  sel_b;
  logic [31:0] adr_b, dat_o_b, dat_i_b;
  logic [2:0]  e_idx_b;

  bq_coef_loader #(.COEFWIDTH(16), .BASE_ADDR(BASE), .TIMEOUT(TO), .VERIFY(1)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
    .a11(a11), .a12(a12), .b10(b10), .b11(b11), .b12(b12),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel), .wb_adr_o(adr),
    .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_ack_i(ack),
    .busy(busy), .done(done), .err_timeout(e_to), .err_mismatch(e_mm), .err_idx(e_idx)
  );

  bq_coef_loader #(.COEFWIDTH(16), .BASE_ADDR(BASE), .TIMEOUT(255), .VERIFY(0)) u_dut_nv (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b),
    .a11(a11), .a12(a12), .b10(b10), .b11(b11), .b12(b12),
    .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b), .wb_sel_o(sel_b), .wb_adr_o(adr_b),
    .wb_dat_o(dat_o_b), .wb_dat_i(dat_i_b), .wb_ack_i(ack_b),
    .busy(busy_b), .done(done_b), .err_timeout(e_to_b), .err_mismatch(e_mm_b),
    .err_idx(e_idx_b)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc_no = 0;
  xfer_t xfer_q[$];
  res_t  res_q[$];
  int    lat_plan [10];
  bit    corrupt [5];
  bit    noise_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc_no);
  endtask

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  // Slave for u_dut: latency is chosen per transfer ordinal (writes 0..4, reads 5..9).
  initial begin
    logic [15:0] smem [5];
    int s_run, ix, ord;
    s_run = 0;
    ack   = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_run = 0;
        ack   = 1'b0;
      end else if (cyc && stb) begin
        ix = int'((adr - BASE) >> 2);
        if (ix < 0 || ix > 4) ix = 0;
        ord = we ? ix : ix + 5;
        s_run++;
        if (lat_plan[ord] != 0 && s_run == lat_plan[ord]) begin
          ack = 1'b1;
          if (we) smem[ix] = dat_o[15:0];
          else    dat_i = {16'h0, smem[ix] ^ (corrupt[ix] ? 16'h0001 : 16'h0000)};
        end else begin
          ack = 1'b0;
        end
      end else begin
        s_run = 0;
        ack   = noise_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        dat_i = $urandom;
      end
    end
  end

  // Slave for u_dut_nv: fixed 3-cycle acknowledge.
  initial begin
    int b_run;
    b_run   = 0;
    ack_b   = 1'b0;
    dat_i_b = '0;
    forever begin
      @(negedge clk);
      if (!rst && cyc_b && stb_b) begin
        b_run++;
        ack_b = (b_run == 3);
      end else begin
        b_run = 0;
        ack_b = 1'b0;
      end
    end
  end

  // Monitor: pops an expected transfer on each stb rise, checks its stb length on the fall,
  // and pops an expected result on each done pulse.
  initial begin
    int    run;
    bit    have;
    xfer_t cur;
    res_t  r;
    run  = 0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run  = 0;
        have = 1'b0;
      end else begin
        if (stb) begin
          if (run == 0) begin
            check("cyc_with_stb", 32'(cyc), 32'd1);
            if (xfer_q.size() == 0) begin
              flag("unexpected_xfer");
              have = 1'b0;
            end else begin
              cur  = xfer_q.pop_front();
              have = 1'b1;
              check("xfer_we", 32'(we), 32'(cur.we));
              check("xfer_adr", adr, cur.adr);
              if (cur.we) check("xfer_dat", dat_o, cur.dat);
            end
          end
          run++;
        end else if (run > 0) begin
          if (have) check("stb_len", 32'(run), 32'(cur.dur));
          run  = 0;
          have = 1'b0;
        end
        if (done) begin
          if (res_q.size() == 0) begin
            flag("spurious_done");
          end else begin
            r = res_q.pop_front();
            check("done_cycle", 32'(cyc_no), 32'(r.at));
            check("err_timeout", 32'(e_to), 32'(r.to));
            check("err_mismatch", 32'(e_mm), 32'(r.mm));
            check("err_idx", 32'(e_idx), 32'(r.idx));
            check("busy_at_done", 32'(busy), 32'd0);
          end
        end
      end
    end
  end

  // Reference model: each coefficient written once in index order, then read back once,
  // a transfer taking its latency plus one gap cycle, aborting after TO unacknowledged cycles.
  task automatic launch(input logic [15:0] c [5], input int lat [10], input bit corr [5],
                        input bit dup);
    int         t, k, j;
    bit         to_f, mm_f;
    logic [2:0] ei;
    xfer_t      x;
    res_t       r;
    @(negedge clk);
    t    = cyc_no + 2;  // first request cycle, one after the start edge
    to_f = 1'b0;
    mm_f = 1'b0;
    ei   = '0;
    for (int p = 0; p < 10 && !to_f; p++) begin
      j     = p % 5;
      x.we  = (p < 5);
      x.adr = BASE + 32'(4 * j);
      x.dat = {{16{c[j][15]}}, c[j]};
      k     = lat[p];
      if (k == 0 || k > TO) begin
        x.dur = TO;
        t    += TO;
        to_f  = 1'b1;
        if (!mm_f) ei = 3'(j);
      end else begin
        x.dur = k;
        t    += k + 1;
        if (p >= 5 && corr[j] && !mm_f) begin
          mm_f = 1'b1;
          ei   = 3'(j);
        end
      end
      xfer_q.push_back(x);
    end
    r.at  = t;
    r.to  = to_f;
    r.mm  = mm_f;
    r.idx = ei;
    res_q.push_back(r);
    lat_plan = lat;
    corrupt  = corr;
    a11 = c[0]; a12 = c[1]; b10 = c[2]; b11 = c[3]; b12 = c[4];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a11 = 16'($urandom); a12 = 16'($urandom); b10 = 16'($urandom);
    b11 = 16'($urandom); b12 = 16'($urandom);
    if (dup) begin
      repeat (3) @(negedge clk);
      a11 = c[0] ^ 16'h0101; a12 = c[1] ^ 16'h0101; b10 = c[2] ^ 16'h0101;
      b11 = c[3] ^ 16'h0101; b12 = c[4] ^ 16'h0101;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (res_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (res_q.size() != 0) begin
      flag("done_never_seen");
      res_q.delete();
    end
    check("xfers_left", 32'(xfer_q.size()), 32'd0);
    xfer_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc_no);
    $fatal(1, "bench watchdog");
  end

  initial begin
    logic [15:0] c [5];
    logic [15:0] happy [5];
    int          lat [10];
    bit          corr [5];
    int          g, e, nx, nrd, stb_tot, done_at, n_done;
    bit          prev, seen;

    happy = '{16'h4001, 16'hC000, 16'h2000, 16'h4000, 16'h2000};
    lat   = '{default: 1};
    corr  = '{default: 1'b0};
    lat_plan = lat;
    corrupt  = corr;
    rst = 1'b1; start = 1'b0; start_b = 1'b0;
    a11 = '0; a12 = '0; b10 = '0; b11 = '0; b12 = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({cyc, stb, we, busy, done, e_to, e_mm}), 32'd0);
    check("rst_adr", adr, BASE);
    check("rst_dat", dat_o, 32'd0);
    check("rst_err_idx", 32'(e_idx), 32'd0);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_ctrl_nv", 32'({cyc_b, stb_b, busy_b, done_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(happy, lat, corr, 1'b0);           // happy path
    wait_done();
    corr[3] = 1'b1;                           // b11 readback corrupted
    launch(happy, lat, corr, 1'b0);
    wait_done();
    corr[3] = 1'b0;
    lat[1] = 0;                               // a12 never acknowledged
    launch(happy, lat, corr, 1'b0);
    wait_done();
    lat[1] = 1;
    c = '{16'h8001, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h1234};
    launch(c, lat, corr, 1'b1);               // second start at E+4 ignored
    wait_done();

    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < 5; j++) begin
        c[j]    = 16'($urandom);
        corr[j] = ($urandom_range(0, 9) == 0);
      end
      for (int p = 0; p < 10; p++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0)      lat[p] = 0;
        else if (r == 1) lat[p] = int'($urandom_range(9, 12));
        else if (r == 2) lat[p] = TO;
        else             lat[p] = int'($urandom_range(1, 4));
      end
      noise_en = ($urandom_range(0, 1) == 1);
      launch(c, lat, corr, ($urandom_range(0, 4) == 0));
      wait_done();
    end
    noise_en = 1'b0;

    // Reset while the b10 write is on the bus.
    lat  = '{default: 1};
    corr = '{default: 1'b0};
    launch(happy, lat, corr, 1'b0);
    g = 0;
    while (!(stb && adr == BASE + 32'h8) && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) flag("rst_test_no_idx2");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", 32'({cyc, stb, busy, done, e_to, e_mm}), 32'd0);
    check("midrst_adr", adr, BASE);
    @(negedge clk);
    rst = 1'b0;
    xfer_q.delete();
    res_q.delete();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | done | stb;
    end
    check("no_activity_after_rst", 32'(seen), 32'd0);
    launch(happy, lat, corr, 1'b0);
    wait_done();

    // VERIFY=0 instance with 3-cycle acknowledge.
    c = '{16'hA5A5, 16'h0F0F, 16'h8000, 16'h7FFF, 16'h0001};
    a11 = c[0]; a12 = c[1]; b10 = c[2]; b11 = c[3]; b12 = c[4];
    @(negedge clk);
    e = cyc_no + 1;
    start_b = 1'b1;
    nx = 0; nrd = 0; stb_tot = 0; done_at = -1; n_done = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (stb_b) begin
        if (!prev) begin
          if (we_b) begin
            if (nx < 5) begin
              check("nv_adr", adr_b, BASE + 32'(4 * nx));
              check("nv_dat", dat_o_b, {{16{c[nx][15]}}, c[nx]});
            end
            nx++;
          end else begin
            nrd++;
          end
        end
        stb_tot++;
      end
      prev = stb_b;
      if (done_b) begin
        n_done++;
        if (done_at < 0) done_at = cyc_no - e;
      end
    end
    check("nv_writes", 32'(nx), 32'd5);
    check("nv_reads", 32'(nrd), 32'd0);
    check("nv_stb_cycles", 32'(stb_tot), 32'd15);
    check("nv_done_cycle", 32'(done_at), 32'd21);
    check("nv_done_count", 32'(n_done), 32'd1);
    check("nv_end_state", 32'({busy_b, e_to_b, e_mm_b}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bq_coef_loader.md
# bq_coef_loader

Wishbone classic master that programs the five biquad coefficient registers (a11, a12, b10, b11, b12) of the filter's Wishbone slave, then optionally reads them back and checks them. It sits between a local controller (start pulse plus coefficient values) and the Wishbone bus feeding the filter's coefficient register file. It removes the need for a CPU on the bus to load a filter.

## Interface

Parameters:
- COEFWIDTH, 16: coefficient width. The slave keeps bits [COEFWIDTH-1:0].
- BASE_ADDR, 32'h3000_0000: byte address of coefficient register 0.
- TIMEOUT, 255: maximum cycles stb may wait for ack before the operation aborts. Range 1..255.
- VERIFY, 1: 1 runs a readback pass after the write pass; 0 skips it.

Ports:
- wb_clk_i  in  1  the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request. Ignored while busy.
- a11, a12, b10, b11, b12  in  COEFWIDTH each  coefficient values, two's-complement fractional. Captured on an accepted start.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  1 = write.
- wb_sel_o  out  4  always 4'hF.
- wb_adr_o  out  32  BASE_ADDR + 4*idx.
- wb_dat_o  out  32  write data, coefficient sign-extended to 32 bits.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse, asserted on success and on abort.
- err_timeout  out  1  sticky; cleared by the next accepted start.
- err_mismatch  out  1  sticky; cleared by the next accepted start.
- err_idx  out  3  index (0..4) of the first failing register.

## Operation

- Register index order: 0=a11, 1=a12, 2=b10, 3=b11, 4=b12. Byte addresses are BASE+0x0, 0x4, 0x8, 0xC, 0x10 (slave decodes adr[5:2]).
- States: IDLE, WR, GAP, RD, FIN.
- IDLE:
  - start captures all five coefficients into shadow registers and clears err_*, idx=0.
  - Go to WR.
- WR:
  - cyc=stb=we=1; adr and dat come from idx.
  - On ack: go to GAP.
  - If idx was 4, the next phase is RD when VERIFY=1, otherwise FIN.
  - idx increments, wrapping from 4 to 0.
- GAP:
  - cyc=stb=0 for exactly one cycle.
  - Then go to the pending WR, RD or FIN.
- RD:
  - cyc=stb=1, we=0.
  - On ack: compare wb_dat_i[COEFWIDTH-1:0] with shadow[idx].
  - On the first inequality, set err_mismatch and load err_idx=idx.
  - Later mismatches leave err_idx unchanged; the read pass continues through idx 4.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Timeout:
  - A wait counter clears when stb rises and counts each stb cycle without ack.
  - When it reaches TIMEOUT: drop cyc/stb, set err_timeout, err_idx=idx, go to FIN. No further transfers are issued.
- start while busy is ignored, and the shadow registers do not change.
- Coefficient inputs may change freely after an accepted start.

## Timing

- All outputs are registered.
- Reset values: cyc, stb, we, busy, done, err_timeout, err_mismatch = 0; adr = BASE_ADDR; dat = 0; err_idx = 0; sel = 4'hF.
- Start sampled at edge E: busy and cyc/stb are high from E+1.
- ack is sampled on the edge on which stb is high. stb falls on that same edge.
- A slave that acks after k cycles of stb costs k+1 cycles per transfer, including GAP.
- With k=1 and VERIFY=1: the last read ack falls at E+20, done is high in the cycle after it, and busy falls with done.
- With k=1 and VERIFY=0: done is high in the 11th cycle after E.
- ack while stb=0 is ignored.
- ack arriving in the same cycle the counter reaches TIMEOUT counts as success.
- wb_rst_i asserted mid-operation: all outputs return to reset values on the next edge, no done pulse, shadows are cleared.

## Structure

- Shared package bq_pkg holds:
  - register index constants (IDX_A11..IDX_B12, NUM_COEF=5);
  - the state encoding;
  - the byte-offset stride 4.
- Single module. No sub-module needed.
- Shadow registers are a 5-entry array indexed by idx.

## Test plan

- **Happy path, VERIFY=1, 1-cycle ack:** a11=16'h4001, a12=16'hC000, b10=16'h2000, b11=16'h4000, b12=16'h2000. Expect writes to 0x3000_0000..0x3000_0010 with dat 32'h0000_4001, 32'hFFFF_C000, ..., then 5 reads, done once at E+21, no errors.
- **Mismatch:** slave model corrupts the b11 readback (returns 16'h4001). Expect err_mismatch=1, err_idx=3, all 5 reads still issued, done asserted.
- **Timeout:** TIMEOUT=8, slave never acks a12. Expect stb high exactly 8 cycles at adr 0x3000_0004, then cyc drops, err_timeout=1, err_idx=1, done pulse, no transfer at 0x3000_0008.
- **Wait states, VERIFY=0:** ack after 3 cycles. Expect each transfer to occupy 4 cycles, done in the 21st cycle after start, and no reads issued.
- **start during busy:** a second start with different coefficients at cycle E+4. Expect it ignored and the originally captured values written.
- **Reset mid-write:** wb_rst_i at idx=2. Expect cyc/stb/busy low on the next edge, no done, and a fresh start afterwards completes normally.
